// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared prescaler and period counter, N channels with
// period-boundary duty updates and an optional triangular "breathe" brightness ramp.
module pwm_multi_channel #(
  parameter int CHANNELS = 4,
  parameter int RES_BITS = 8,
  parameter int PRESCALE = 390,
  parameter int CH_BITS  = 2
) (
  input  logic                clk_100MHz,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CH_BITS-1:0]  wr_ch,
  input  logic [RES_BITS-1:0] wr_duty,
  input  logic                wr_breathe,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  // A one-bit prescaler is kept even for PRESCALE = 1 so the width is never zero.
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]    pre_cnt;
  logic [RES_BITS-1:0] cnt;
  logic                tick;
  logic                boundary;

  logic [RES_BITS-1:0] pending_duty [CHANNELS];
  logic [RES_BITS-1:0] active_duty  [CHANNELS];
  logic [CHANNELS-1:0] pending_mode;
  logic [CHANNELS-1:0] dir;

  assign tick     = (pre_cnt == PRE_W'(PRESCALE - 1));
  assign boundary = tick && (cnt == '1);

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt      <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
        cnt     <= cnt + RES_BITS'(1);
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      period_start <= boundary;
    end
  end

  // The boundary load reads pending values from before this edge, so a write landing
  // on the boundary clock is held over to the following boundary.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pending_duty[i] <= '0;
        active_duty[i]  <= '0;
      end
      pending_mode <= '0;
      dir          <= '1;
      pwm_out      <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= (cnt < active_duty[i]);
        if (boundary) begin
          if (!pending_mode[i]) begin
            active_duty[i] <= pending_duty[i];
            dir[i]         <= 1'b1;
          end else if (dir[i]) begin
            if (active_duty[i] < pending_duty[i]) begin
              active_duty[i] <= active_duty[i] + RES_BITS'(1);
            end else begin
              active_duty[i] <= pending_duty[i];
              dir[i]         <= 1'b0;
            end
          end else begin
            if (active_duty[i] != '0) begin
              active_duty[i] <= active_duty[i] - RES_BITS'(1);
            end else begin
              dir[i] <= 1'b1;
            end
          end
        end
        if (wr_en && (wr_ch == CH_BITS'(i))) begin
          pending_duty[i] <= wr_duty;
          pending_mode[i] <= wr_breathe;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Randomised self-checking bench for pwm_multi_channel, comparing a 4-channel and a
// 3-channel instance against a period-level behavioural model of duty and breathe rules.
module tb_pwm_multi_channel;

  localparam int CH     = 4;
  localparam int RB     = 4;
  localparam int PS     = 2;
  localparam int CB     = 2;
  localparam int STEPS  = 1 << RB;
  localparam int PERIOD = PS * STEPS;

  logic          clk_100MHz = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [CB-1:0] wr_ch;
  logic [RB-1:0] wr_duty;
  logic          wr_breathe;
  logic [CH-1:0] pwm_out;
  logic          period_start;
  logic [2:0]    pwm_out3;
  logic          period_start3;

  int checks = 0;
  int errors = 0;

  // Model state: per-channel duty of the running period plus the last written settings.
  int pend_duty [CH];
  bit pend_mode [CH];
  int act       [CH];
  bit dir_up    [CH];
  int high_cnt  [CH];
  int e;
  bit breathe_arm;
  bit breathe_logging;
  int breathe_log [$];

  always #5 clk_100MHz = ~clk_100MHz;

  pwm_multi_channel #(.CHANNELS(CH), .RES_BITS(RB), .PRESCALE(PS), .CH_BITS(CB)) dut (
    .clk_100MHz  (clk_100MHz),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .wr_breathe  (wr_breathe),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  // Same stimulus, three channels: writes to channel 3 must be ignored here.
  pwm_multi_channel #(.CHANNELS(3), .RES_BITS(RB), .PRESCALE(PS), .CH_BITS(CB)) dut3 (
    .clk_100MHz  (clk_100MHz),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .wr_breathe  (wr_breathe),
    .pwm_out     (pwm_out3),
    .period_start(period_start3)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at clock %0d: got %0d, expected %0d", tag, e, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      pend_duty[i] = 0;
      pend_mode[i] = 1'b0;
      act[i]       = 0;
      dir_up[i]    = 1'b1;
      high_cnt[i]  = 0;
    end
    e = 0;
  endtask

  // Duty for the next period: static copies the target, breathe walks one step toward
  // the peak or toward zero and turns around for one period at either end.
  task automatic model_boundary();
    for (int i = 0; i < CH; i++) begin
      if (!pend_mode[i]) begin
        act[i]    = pend_duty[i];
        dir_up[i] = 1'b1;
      end else if (dir_up[i]) begin
        if (act[i] < pend_duty[i]) act[i] = act[i] + 1;
        else begin
          act[i]    = pend_duty[i];
          dir_up[i] = 1'b0;
        end
      end else begin
        if (act[i] > 0) act[i] = act[i] - 1;
        else dir_up[i] = 1'b1;
      end
    end
  endtask

  // One clock: drive inputs, take the edge, then check outputs against the model.
  // Clock e (1-based since reset release) sits at step ((e-1)/PS) of period (e-1)/PERIOD.
  task automatic apply_stimulus(input bit en, input int ch, input int duty, input bit br);
    logic [CH-1:0] exp_pwm;
    wr_en      = en;
    wr_ch      = CB'(ch);
    wr_duty    = RB'(duty);
    wr_breathe = br;
    @(posedge clk_100MHz);
    #1;
    e++;
    for (int i = 0; i < CH; i++) exp_pwm[i] = ((((e - 1) / PS) % STEPS) < act[i]);
    check_output("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    check_output("pwm_out_3ch", 32'(pwm_out3), 32'(exp_pwm[2:0]));
    check_output("period_start", 32'(period_start), 32'((e % PERIOD) == 0));
    check_output("period_start_3ch", 32'(period_start3), 32'((e % PERIOD) == 0));
    for (int i = 0; i < CH; i++) high_cnt[i] += int'(pwm_out[i]);
    if ((e % PERIOD) == 0) begin
      for (int i = 0; i < CH; i++) begin
        check_output($sformatf("high_clocks_ch%0d", i), 32'(high_cnt[i]), 32'(PS * act[i]));
      end
      if (breathe_logging) breathe_log.push_back(high_cnt[1]);
      if (breathe_arm) begin
        breathe_arm     = 1'b0;
        breathe_logging = 1'b1;
      end
      for (int i = 0; i < CH; i++) high_cnt[i] = 0;
      model_boundary();
    end
    if (en && ch < CH) begin
      pend_duty[ch] = duty;
      pend_mode[ch] = br;
    end
    wr_en = 1'b0;
  endtask

  task automatic run_until(input int phase);
    apply_stimulus(1'b0, 0, 0, 1'b0);
    while ((e % PERIOD) != phase) apply_stimulus(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int breathe_exp [9];
    breathe_exp = '{1, 2, 3, 3, 2, 1, 0, 0, 1};
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_ch = '0;
    wr_duty = '0;
    wr_breathe = 1'b0;
    breathe_arm = 1'b0;
    breathe_logging = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_100MHz);
    #1;
    check_output("reset_pwm_out", 32'(pwm_out), 32'(0));
    check_output("reset_period_start", 32'(period_start), 32'(0));
    rst_n = 1'b1;

    $display("[TB] static duties");
    apply_stimulus(1'b1, 0, 4, 1'b0);
    apply_stimulus(1'b1, 1, 0, 1'b0);
    apply_stimulus(1'b1, 2, 15, 1'b0);
    apply_stimulus(1'b1, 3, 8, 1'b0);
    while (e < 3 * PERIOD) apply_stimulus(1'b0, 0, 0, 1'b0);

    $display("[TB] mid-period update");
    run_until(10);
    apply_stimulus(1'b1, 0, 12, 1'b0);
    repeat (2 * PERIOD) apply_stimulus(1'b0, 0, 0, 1'b0);

    $display("[TB] write on boundary clock");
    run_until(PERIOD - 1);
    apply_stimulus(1'b1, 3, 2, 1'b0);
    repeat (2 * PERIOD) apply_stimulus(1'b0, 0, 0, 1'b0);

    $display("[TB] breathe ramp");
    run_until(5);
    apply_stimulus(1'b1, 1, 3, 1'b1);
    breathe_arm = 1'b1;
    repeat (10 * PERIOD) apply_stimulus(1'b0, 0, 0, 1'b0);
    breathe_logging = 1'b0;
    check_output("breathe_periods_logged", 32'(breathe_log.size() >= 9), 32'(1));
    for (int k = 0; k < 9 && k < breathe_log.size(); k++) begin
      check_output($sformatf("breathe_period%0d", k), 32'(breathe_log[k]),
                   32'(PS * breathe_exp[k]));
    end

    $display("[TB] asynchronous reset mid-period");
    run_until(17);
    rst_n = 1'b0;
    #2;
    check_output("async_reset_pwm_out", 32'(pwm_out), 32'(0));
    check_output("async_reset_pwm_out_3ch", 32'(pwm_out3), 32'(0));
    check_output("async_reset_period_start", 32'(period_start), 32'(0));
    model_reset();
    @(posedge clk_100MHz);
    #1;
    rst_n = 1'b1;
    apply_stimulus(1'b1, 2, 6, 1'b0);
    while (e < PERIOD + 4) apply_stimulus(1'b0, 0, 0, 1'b0);

    $display("[TB] random writes");
    for (int n = 0; n < 1600; n++) begin
      apply_stimulus($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, STEPS - 1)), $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM generator for LED brightness control, sitting between the board switches/control logic and the LED pins. It replaces the fixed 2-bit, single-output, separate-divider arrangement with one shared prescaler and period counter, N independent channels of configurable resolution, duty-cycle writes that take effect only at period boundaries (no glitches), and a per-channel "breathe" mode that ramps brightness up and down automatically.

## Interface
- CHANNELS, 4, number of independent PWM outputs (1..16)
- RES_BITS, 8, duty/period counter width; period = 2^RES_BITS ticks
- PRESCALE, 390, clk_100MHz cycles per tick (>= 1); default gives about 1 kHz PWM at RES_BITS=8
- CH_BITS, 2, width of channel select; must satisfy 2^CH_BITS >= CHANNELS

Ports:
- clk_100MHz  input  1  system clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  one-cycle write strobe
- wr_ch  input  CH_BITS  channel addressed by the write; values >= CHANNELS are ignored
- wr_duty  input  RES_BITS  target duty (static) or peak duty (breathe)
- wr_breathe  input  1  mode written with the duty: 0 = static, 1 = breathe
- pwm_out  output  CHANNELS  registered PWM outputs
- period_start  output  1  one-cycle pulse marking the first clock of each period

## Operation
- Prescaler pre_cnt counts 0..PRESCALE-1 and wraps. tick = (pre_cnt == PRESCALE-1).
- Period counter cnt (RES_BITS) increments on tick and wraps from 2^RES_BITS-1 to 0. boundary = tick && cnt == 2^RES_BITS-1.
- Per channel: pending_duty, pending_mode (write side); active_duty, dir (1 = up).
- Write: when wr_en is high and wr_ch < CHANNELS, set pending_duty[wr_ch] <= wr_duty and pending_mode[wr_ch] <= wr_breathe. Only the addressed channel changes.
- On boundary, each channel updates active_duty from its pending registers as they stood before this clock edge:
  - Static: active_duty <= pending_duty; dir <= 1.
  - Breathe, dir=1: if active_duty < pending_duty, increment it by 1. Otherwise set it to pending_duty and set dir to 0.
  - Breathe, dir=0: if active_duty > 0, decrement it by 1. Otherwise set dir to 1.
  - Breathe peak 0: output stays low.
  - Lowering the peak below active_duty: the next boundary clamps active_duty to the new peak and starts descending.
- Output compare, every clock: pwm_out[i] <= (cnt < active_duty[i]).
  - Duty D gives D high ticks out of 2^RES_BITS.
  - D = 0 is constantly low.
  - Full-on is never reached: maximum is (2^RES_BITS-1)/2^RES_BITS.
- period_start <= boundary, registered.

## Timing
- Reset, asynchronous, while rst_n = 0: pre_cnt, cnt, all pending/active duty = 0; all modes static; dir = 1; pwm_out = 0; period_start = 0. Reset mid-period aborts immediately.
- After release: the first tick occurs PRESCALE clocks after the first rising edge with rst_n = 1.
- pwm_out lags the (cnt, active_duty) state by 1 clock.
- period_start is high for exactly 1 clock, the same clock cnt first reads 0. The pwm_out bits reflecting the new active_duty appear 1 clock later.
- Write-to-effect latency: from the next boundary, up to PRESCALE*2^RES_BITS clocks.
- Write in the same clock as boundary: it is stored in pending, but the load uses the old pending value, so the write applies at the following boundary.
- Multiple writes to one channel within a period: the last write wins.
- Breathe full cycle for peak P > 0: 2P+2 periods (P up-steps, 1 turn at peak, P down-steps, 1 turn at zero).
- PRESCALE = 1: tick is high every clock; the period is 2^RES_BITS clocks.

## Test plan
Bench parameters: CHANNELS=4, RES_BITS=4, PRESCALE=2, CH_BITS=2, giving a period of 32 clocks.

- Reset: hold rst_n low mid-period with duties loaded -> pwm_out=0000 and period_start=0 asynchronously; after release, the first period_start occurs 32 clocks later.
- Static duty: write ch0=4, ch1=0, ch2=15, ch3=8, then wait one boundary -> each period has high durations of 8, 0, 30 and 16 clocks respectively; ch1 is never high.
- Glitch-free update: write ch0=12 mid-period while it runs at 4 -> the current period still shows an 8-clock pulse; the next period shows a 24-clock pulse starting 1 clock after period_start.
- Boundary collision: write ch3=2 in the exact clock of boundary -> the next period keeps the old duty; the period after shows a 4-clock pulse.
- Breathe: write ch1 peak=3, breathe -> per-period duty sequence from the next boundary is 1,2,3,3,2,1,0,0,1,… (8-period cycle).
- Invalid address: with CHANNELS=3 and wr_ch=3 -> no channel's pending duty changes.
